seq_multiplier: RTL and testbench

//   Iterative shift-and-add unsigned multiplier. Feeds the datapath result registers.
//   - clr_out drives the result register's init input.
//   - done drives its load input.
//   - product drives its in_value input.
//   One multiplication per start handshake. BIT_WIDTH+1 cycles per operation. One adder, no array multiplier.

---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 102 ++++++++++
 tb/tb_seq_multiplier.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle between a requester and the sequential multiplier.
interface seq_multiplier_if #(
  parameter int BIT_WIDTH = 16
);
  logic                     start;
  logic                     abort;
  logic [BIT_WIDTH-1:0]     op_a;
  logic [BIT_WIDTH-1:0]     op_b;
  logic                     busy;
  logic                     clr_out;
  logic                     done;
  logic [2*BIT_WIDTH-1:0]   product;

  modport master (
    output start, abort, op_a, op_b,
    input  busy, clr_out, done, product
  );

  modport slave (
    input  start, abort, op_a, op_b,
    output busy, clr_out, done, product
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-and-add unsigned multiplier, one multiplier bit per cycle.
//
// state | meaning
// IDLE  | waiting for start; product holds last result
// CALC  | one partial product per cycle, LSB of op_b first
// DONE  | product valid, done pulses for one cycle
module seq_multiplier #(
  parameter int BIT_WIDTH = 16
) (
  input logic clk,
  input logic rst_n,
  seq_multiplier_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam int CW = (BIT_WIDTH > 1) ? $clog2(BIT_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_WIDTH - 1);

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [BIT_WIDTH-1:0]   a_reg;
  logic [BIT_WIDTH-1:0]   b_reg;
  logic [2*BIT_WIDTH-1:0] acc;
  logic [2*BIT_WIDTH-1:0] addend;
  logic [2*BIT_WIDTH-1:0] acc_next;
  logic                   busy;
  logic                   clr_out;
  logic                   done;
  logic [2*BIT_WIDTH-1:0] product;

  // Single adder: the shifted multiplicand is added only when the current multiplier bit is set.
  always_comb begin
    addend   = '0;
    if (b_reg[cnt]) addend = {{BIT_WIDTH{1'b0}}, a_reg} << cnt;
    acc_next = acc + addend;
  end

  // Sequencer with registered outputs; abort outranks start in IDLE and is ignored in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      busy    <= 1'b0;
      clr_out <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            a_reg   <= bus.op_a;
            b_reg   <= bus.op_b;
            acc     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            clr_out <= 1'b1;
            state   <= CALC;
          end
        end
        CALC: begin
          clr_out <= 1'b0;
          if (bus.abort) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            acc <= acc_next;
            if (cnt == CNT_LAST) begin
              cnt     <= '0;
              product <= acc_next;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          clr_out <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.clr_out = clr_out;
  assign bus.done    = done;
  assign bus.product = product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomized checks of seq_multiplier at BIT_WIDTH 16 and 8.
module tb_seq_multiplier;

  logic clk;
  logic rst_n;

  seq_multiplier_if #(.BIT_WIDTH(16)) bus16 ();
  seq_multiplier_if #(.BIT_WIDTH(8))  bus8 ();

  seq_multiplier #(.BIT_WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  seq_multiplier #(.BIT_WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream result registers: init on clr_out, load on done.
  logic [31:0] res16;
  logic [15:0] res8;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res16 <= '0;
      res8  <= '0;
    end else begin
      if (bus16.clr_out)   res16 <= '0;
      else if (bus16.done) res16 <= bus16.product;
      if (bus8.clr_out)    res8  <= '0;
      else if (bus8.done)  res8  <= bus8.product;
    end
  end

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the 16-bit unit with timing, pulse and latching checks.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input string name);
    int done_cyc, done_cnt, clr_cyc, clr_cnt, busy_cnt;
    bus16.op_a  = a;
    bus16.op_b  = b;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    done_cyc = -1; done_cnt = 0; clr_cyc = -1; clr_cnt = 0; busy_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      if (bus16.done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (bus16.clr_out) begin
        clr_cnt++;
        if (clr_cyc < 0) clr_cyc = c;
      end
      if (bus16.busy) busy_cnt++;
      if (c == 5) begin
        bus16.op_a = ~a;
        bus16.op_b = b ^ 16'h5A5A;
      end
      bus16.start = (c == 8);
      if (c < 20) tick();
    end
    bus16.start = 1'b0;
    chk({name, "_product"}, 64'(bus16.product), 64'(exp));
    chk({name, "_resreg"},  64'(res16), 64'(exp));
    chk({name, "_done_cyc"}, 64'(done_cyc), 64'(17));
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'(1));
    chk({name, "_clr_cyc"}, 64'(clr_cyc), 64'(1));
    chk({name, "_clr_cnt"}, 64'(clr_cnt), 64'(1));
    chk({name, "_busy_cnt"}, 64'(busy_cnt), 64'(17));
  endtask

  function automatic logic [15:0] fa(input int c);
    return 16'(c * 37 + 5);
  endfunction

  function automatic logic [15:0] fb(input int c);
    return 16'(c * 11 + 1);
  endfunction

  initial begin
    logic [31:0] prev;
    int          n_done;
    int          n_good;
    int          c;
    logic [15:0] ra, rb;
    logic [7:0]  sa, sb;

    vecs[0]  = '{16'd3,    16'd5,    32'h0000_000F};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2]  = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3]  = '{16'h1234, 16'h0000, 32'h0000_0000};
    vecs[4]  = '{16'h0001, 16'h0001, 32'h0000_0001};
    vecs[5]  = '{16'hFFFF, 16'h0001, 32'h0000_FFFF};
    vecs[6]  = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
    vecs[7]  = '{16'h8000, 16'h8000, 32'h4000_0000};
    vecs[8]  = '{16'h00FF, 16'h0100, 32'h0000_FF00};
    vecs[9]  = '{16'h1234, 16'h5678, 32'h0626_0060};
    vecs[10] = '{16'hFFFF, 16'h0002, 32'h0001_FFFE};
    vecs[11] = '{16'd7,    16'd9,    32'h0000_003F};

    rst_n = 1'b0;
    bus16.start = 1'b0; bus16.abort = 1'b0; bus16.op_a = '0; bus16.op_b = '0;
    bus8.start  = 1'b0; bus8.abort  = 1'b0; bus8.op_a  = '0; bus8.op_b  = '0;
    #12;
    chk("rst_busy",    64'(bus16.busy), 64'(0));
    chk("rst_clr",     64'(bus16.clr_out), 64'(0));
    chk("rst_done",    64'(bus16.done), 64'(0));
    chk("rst_product", 64'(bus16.product), 64'(0));
    rst_n = 1'b1;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));
    end

    // Start held high with operands changing every cycle: accepted every 18 cycles.
    n_done = 0;
    n_good = 0;
    for (c = 0; c < 54; c++) begin
      bus16.op_a  = fa(c);
      bus16.op_b  = fb(c);
      bus16.start = 1'b1;
      tick();
      if (bus16.done) begin
        n_done++;
        if (c >= 16 && ((c - 16) % 18) == 0) n_good++;
        chk($sformatf("held_product_c%0d", c), 64'(bus16.product),
            64'({16'b0, fa(c - 16)} * {16'b0, fb(c - 16)}));
      end
    end
    bus16.start = 1'b0;
    chk("held_done_cnt", 64'(n_done), 64'(3));
    chk("held_done_pos", 64'(n_good), 64'(3));
    for (int i = 0; i < 4; i++) tick();

    // Abort in the middle of 7*9.
    prev = bus16.product;
    bus16.op_a = 16'd7; bus16.op_b = 16'd9; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    for (int i = 1; i < 8; i++) tick();
    bus16.abort = 1'b1;
    tick();
    bus16.abort = 1'b0;
    chk("abort_busy", 64'(bus16.busy), 64'(0));
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus16.done) n_done++;
      tick();
    end
    chk("abort_no_done", 64'(n_done), 64'(0));
    chk("abort_product", 64'(bus16.product), 64'(prev));
    do_op(16'd2, 16'd2, 32'd4, "after_abort");

    // Abort while in DONE is ignored.
    bus16.op_a = 16'd5; bus16.op_b = 16'd6; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    for (int i = 1; i < 17; i++) tick();
    bus16.abort = 1'b1;
    chk("abort_done_pulse", 64'(bus16.done), 64'(1));
    tick();
    bus16.abort = 1'b0;
    chk("abort_done_end", 64'(bus16.done), 64'(0));
    chk("abort_done_product", 64'(bus16.product), 64'(30));

    // Abort and start together in IDLE: stay idle.
    bus16.op_a = 16'd11; bus16.op_b = 16'd13; bus16.start = 1'b1; bus16.abort = 1'b1;
    tick();
    bus16.start = 1'b0; bus16.abort = 1'b0;
    chk("idle_abort_busy", 64'(bus16.busy), 64'(0));
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus16.done) n_done++;
      tick();
    end
    chk("idle_abort_no_done", 64'(n_done), 64'(0));
    chk("idle_abort_product", 64'(bus16.product), 64'(30));

    // Reset asserted at cycle 10 of an operation.
    bus16.op_a = 16'hABCD; bus16.op_b = 16'h0003; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_busy",    64'(bus16.busy), 64'(0));
    chk("midrst_clr",     64'(bus16.clr_out), 64'(0));
    chk("midrst_done",    64'(bus16.done), 64'(0));
    chk("midrst_product", 64'(bus16.product), 64'(0));
    #2;
    rst_n = 1'b1;
    n_done = 0;
    c = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus16.done) n_done++;
      if (bus16.busy) c++;
    end
    chk("midrst_no_done", 64'(n_done), 64'(0));
    chk("midrst_idle", 64'(c), 64'(0));
    do_op(16'h1234, 16'h0010, 32'h0001_2340, "after_rst");

    // Randomized operations, 16-bit unit.
    for (int k = 0; k < 150; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (k == 0) ra = 16'h0;
      bus16.op_a = ra; bus16.op_b = rb; bus16.start = 1'b1;
      tick();
      bus16.start = 1'b0;
      c = 0;
      while (!bus16.done && c < 40) begin
        tick();
        c++;
      end
      chk("rand16_latency", 64'(c), 64'(16));
      chk("rand16_product", 64'(bus16.product), 64'({16'b0, ra} * {16'b0, rb}));
      tick();
      chk("rand16_resreg", 64'(res16), 64'({16'b0, ra} * {16'b0, rb}));
    end

    // Randomized operations, 8-bit unit.
    for (int k = 0; k < 150; k++) begin
      sa = 8'($urandom);
      sb = 8'($urandom);
      if (k == 0) begin sa = 8'hFF; sb = 8'hFF; end
      bus8.op_a = sa; bus8.op_b = sb; bus8.start = 1'b1;
      tick();
      bus8.start = 1'b0;
      c = 0;
      while (!bus8.done && c < 40) begin
        tick();
        c++;
      end
      chk("rand8_latency", 64'(c), 64'(8));
      chk("rand8_product", 64'(bus8.product), 64'({8'b0, sa} * {8'b0, sb}));
      tick();
      chk("rand8_resreg", 64'(res8), 64'({8'b0, sa} * {8'b0, sb}));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
